fetch_decode_regfile: RTL

Front half of the single-cycle datapath: holds the program counter, fetches a 16-bit instruction from the combinational instruction ROM, decodes it, and owns the register file. It drives `ALUSrc`, `Read_Data` and `Imm_Data` into the execution/writeback stage and writes that stage's `Result` back into the register file at the next rising clock edge. It also implements the run/halt control and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/register_file.sv | 36 +++
 rtl/fetch_decode_regfile.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle datapath: instruction fields,
// opcodes, controller states and default widths.
package cpu_pkg;

    localparam int PC_WIDTH_DEF   = 8;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int REG_IDX_W      = 4;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_LI   = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_NOP  = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/register_file.sv
// NUM_REGS x DATA_WIDTH register file: one synchronous write port, two
// asynchronous read ports, asynchronous clear. Reads return the old value.
module register_file
    import cpu_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_IDX_W-1:0]  raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [REG_IDX_W-1:0]  raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_REGS)) begin
            regs[waddr] <= wdata;
        end
    end

    // Indices beyond NUM_REGS read as zero rather than aliasing.
    assign rdata_a = (int'(raddr_a) < NUM_REGS) ? regs[raddr_a] : '0;
    assign rdata_b = (int'(raddr_b) < NUM_REGS) ? regs[raddr_b] : '0;

endmodule

// File: rtl/fetch_decode_regfile.sv
// Front half of the single-cycle datapath: PC, fetch, decode, register file,
// run/halt controller and a saturating retired-instruction counter.
module fetch_decode_regfile
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PC_WIDTH-1:0]   Instr_Addr,
    input  logic [15:0]           Instr,
    input  logic [DATA_WIDTH-1:0] Result,
    output logic                  ALUSrc,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic [DATA_WIDTH-1:0] Imm_Data,
    output logic                  Halted,
    output logic [15:0]           Retired,
    input  logic [3:0]            Dbg_Sel,
    output logic [DATA_WIDTH-1:0] Dbg_Data
);

    // Handshake: none. One instruction is consumed every RUN cycle; Result
    // must settle combinationally from Read_Data/Imm_Data before the edge.

    state_t                state, state_next;
    logic [PC_WIDTH-1:0]   pc, pc_next;
    logic [15:0]           retired, retired_next;
    logic [3:0]            opcode;
    logic [REG_IDX_W-1:0]  rd;
    logic [7:0]            imm;
    logic                  is_write_op;
    logic                  we;

    always_comb begin
        opcode      = Instr[OPC_MSB:OPC_LSB];
        rd          = Instr[RD_MSB:RD_LSB];
        imm         = Instr[IMM_MSB:IMM_LSB];
        is_write_op = (opcode == OP_LI) || (opcode == OP_ADDI);
        ALUSrc      = (opcode == OP_ADDI);
        Imm_Data    = DATA_WIDTH'(imm);
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        retired_next = retired;
        we           = 1'b0;
        case (state)
            RUN: begin
                if (opcode == OP_HALT) begin
                    state_next = HALTED;
                end else begin
                    pc_next = pc + 1'b1;
                    we      = is_write_op;
                    if (retired != 16'hFFFF) begin
                        retired_next = retired + 16'd1;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pc      <= '0;
            retired <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            retired <= retired_next;
        end
    end

    register_file #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_register_file (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (rd),
        .wdata   (Result),
        .raddr_a (rd),
        .rdata_a (Read_Data),
        .raddr_b (Dbg_Sel),
        .rdata_b (Dbg_Data)
    );

    assign Instr_Addr = pc;
    assign Halted     = (state == HALTED);
    assign Retired    = retired;

endmodule
